pwm_multi_ctrl: RTL

PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_channel.sv | 111 +++++++++++
 rtl/pwm_multi_ctrl.sv | 56 +++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the per-channel configuration bundle for pwm_multi_ctrl.
// Config fields are held at a fixed maximum width; channels compare at that width.
package pwm_pkg;

    localparam int PWM_CNT_W   = 28;
    localparam int PWM_DT_W    = 8;
    localparam int PWM_CNT_MAX = 32;
    localparam int PWM_DT_MAX  = 16;

    typedef struct packed {
        logic [PWM_CNT_MAX-1:0] period;
        logic [PWM_CNT_MAX-1:0] duty;
        logic [PWM_DT_MAX-1:0]  dead;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: counter, double-buffered config, registered outputs.
// Ports: i_clk, i_rst_n, i_wr/i_cfg (pending load), i_en, o_pwm, o_pwm_n, o_tick, o_upd.
// Macro PWM_MULTI_DEADTIME_EN adds dead-time insertion on the complementary pair.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W,
    parameter int DT_W  = PWM_DT_W
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_wr,
    input  pwm_cfg_t i_cfg,
    input  logic     i_en,
    output logic     o_pwm,
    output logic     o_pwm_n,
    output logic     o_tick,
    output logic     o_upd
);

    pwm_cfg_t               r_act;
    pwm_cfg_t               r_pend;
    logic                   r_upd;
    logic                   r_tick;
    logic                   r_out;
    logic                   r_out_n;
    logic [CNT_W-1:0]       r_cnt;
    logic [PWM_CNT_MAX-1:0] w_cnt;
    logic                   w_zero;
    logic                   w_last;
    logic                   w_run;
    logic                   w_raw;
    logic                   w_apply;

    // A zero period means idle: both outputs low, and pending values
    // are taken on every edge as if each cycle were a wrap.
    always_comb begin
        w_cnt   = PWM_CNT_MAX'(r_cnt);
        w_zero  = (r_act.period == '0);
        w_last  = !w_zero && (w_cnt >= r_act.period - PWM_CNT_MAX'(1));
        w_run   = i_en && !w_zero;
        w_raw   = w_run && (w_cnt < r_act.duty);
        w_apply = r_upd && (!i_en || w_zero || w_last);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_act  <= '0;
            r_pend <= '0;
            r_upd  <= 1'b0;
        end else begin
            if (!w_run || w_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            r_tick <= w_run && w_last;
            // A write landing on the apply edge stays pending for the next wrap.
            if (w_apply)
                r_act <= r_pend;
            if (i_wr)
                r_pend <= i_cfg;
            r_upd <= i_wr || (r_upd && !w_apply);
        end
    end

`ifdef PWM_MULTI_DEADTIME_EN
    logic            r_raw_q;
    logic [DT_W-1:0] r_since;
    logic [DT_W-1:0] w_since;
    logic            w_dt_ok;

    // Cycles since the raw drive last changed; each side may only rise
    // once this reaches the dead-time, so short pulses never appear.
    always_comb begin
        w_since = (w_raw != r_raw_q) ? '0 : r_since;
        w_dt_ok = (PWM_DT_MAX'(w_since) >= r_act.dead);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_raw_q <= 1'b0;
            r_since <= '0;
            r_out   <= 1'b0;
            r_out_n <= 1'b0;
        end else begin
            r_raw_q <= w_raw;
            r_since <= (&w_since) ? w_since : w_since + DT_W'(1);
            r_out   <= w_raw && w_dt_ok;
            r_out_n <= w_run && !w_raw && w_dt_ok;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out   <= 1'b0;
            r_out_n <= 1'b0;
        end else begin
            r_out   <= w_raw;
            r_out_n <= w_run && !w_raw;
        end
    end
`endif

    assign o_pwm   = r_out;
    assign o_pwm_n = r_out_n;
    assign o_tick  = r_tick;
    assign o_upd   = r_upd;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: write decode plus NUM_CH pwm_channel instances.
// Ports: CLK, RST_N, WR_EN/WR_CH/WR_PERIOD/WR_DUTY/WR_DEAD, CH_EN,
// PWM_OUT, PWM_OUT_N, PERIOD_TICK, UPD_PEND. Macro: PWM_MULTI_DEADTIME_EN.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = PWM_CNT_W,
    parameter int DT_W   = PWM_DT_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [CH_W-1:0]   WR_CH,
    input  logic [CNT_W-1:0]  WR_PERIOD,
    input  logic [CNT_W-1:0]  WR_DUTY,
    input  logic [DT_W-1:0]   WR_DEAD,
    input  logic [NUM_CH-1:0] CH_EN,
    output logic [NUM_CH-1:0] PWM_OUT,
    output logic [NUM_CH-1:0] PWM_OUT_N,
    output logic [NUM_CH-1:0] PERIOD_TICK,
    output logic [NUM_CH-1:0] UPD_PEND
);

    pwm_cfg_t          w_cfg;
    logic [NUM_CH-1:0] w_wr;

    always_comb begin
        w_cfg        = '0;
        w_cfg.period = PWM_CNT_MAX'(WR_PERIOD);
        w_cfg.duty   = PWM_CNT_MAX'(WR_DUTY);
        w_cfg.dead   = PWM_DT_MAX'(WR_DEAD);
    end

    // Out-of-range channel numbers match no instance and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = WR_EN && (WR_CH == CH_W'(g));

        pwm_channel #(
            .CNT_W(CNT_W),
            .DT_W (DT_W)
        ) u_ch (
            .i_clk  (CLK),
            .i_rst_n(RST_N),
            .i_wr   (w_wr[g]),
            .i_cfg  (w_cfg),
            .i_en   (CH_EN[g]),
            .o_pwm  (PWM_OUT[g]),
            .o_pwm_n(PWM_OUT_N[g]),
            .o_tick (PERIOD_TICK[g]),
            .o_upd  (UPD_PEND[g])
        );
    end

endmodule
